// File: rtl/fabclk_rst_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fabclk_rst_pkg
//  Description : Shared state encodings and reset-cause codes for the fabric
//                clock reset sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package fabclk_rst_pkg;

    // Sequencer states; the numeric values are exported on SEQ_STATE
    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABILISE  = 3'd1,
        REL_FABRIC = 3'd2,
        RUN        = 3'd3,
        DBG_HOLD   = 3'd4
    } seq_state_t;

    // Cause of the most recent reset, reported on RESET_CAUSE
    localparam logic [1:0] CAUSE_POR  = 2'b00;
    localparam logic [1:0] CAUSE_LOCK = 2'b01;
    localparam logic [1:0] CAUSE_BTN  = 2'b10;
    localparam logic [1:0] CAUSE_DBG  = 2'b11;

endpackage : fabclk_rst_pkg
`default_nettype wire

// File: rtl/rst_sync_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : rst_sync_debounce
//  Description : Multi-flop synchroniser for an asynchronous level, with an
//                optional debounce stage. With DEBOUNCE_CYCLES = 0 the
//                synchroniser output is passed straight through; otherwise
//                the output only follows after the synchronised level has
//                held for DEBOUNCE_CYCLES consecutive cycles (resets to 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module rst_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_level
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_out;

    // Shift the asynchronous input through the synchroniser chain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign w_sync_out = r_sync[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_sync_only
            assign o_level = w_sync_out;
        end else begin : g_debounce
            localparam int             c_cnt_w = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

            logic [c_cnt_w-1:0] r_cnt;
            logic               r_level;

            // Accept a new level only after it has been stable long enough;
            // any return to the current level restarts the count
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt   <= '0;
                    r_level <= 1'b1;
                end else if (w_sync_out == r_level) begin
                    r_cnt   <= '0;
                end else if (r_cnt == c_last) begin
                    r_level <= w_sync_out;
                    r_cnt   <= '0;
                end else begin
                    r_cnt   <= r_cnt + 1'b1;
                end
            end

            assign o_level = r_level;
        end
    endgenerate

endmodule : rst_sync_debounce
`default_nettype wire

// File: rtl/fabclk_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : fabclk_reset_sequencer
//  Description : Sequences the active-low fabric and CPU resets from PLL lock,
//                the debounced push-button and the debug reset request.
//                Tracks a sticky lock-lost flag and the cause of the last reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module fabclk_reset_sequencer
    import fabclk_rst_pkg::*;
#(
    parameter int SYNC_STAGES        = 2,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int DEBOUNCE_CYCLES    = 50000,
    parameter int CPU_DELAY_CYCLES   = 16,
    parameter int NDM_HOLD_CYCLES    = 32
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PLL_LOCK,
    input  logic       EXT_RST_N,
    input  logic       NDM_RESET,
    input  logic       CLR_STICKY,
    output logic       FABRIC_RESET_N,
    output logic       CPU_RESET_N,
    output logic [2:0] SEQ_STATE,
    output logic       LOCK_LOST,
    output logic [1:0] RESET_CAUSE
);

    localparam int c_stab_w = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int c_cpu_w  = $clog2(CPU_DELAY_CYCLES + 1);
    localparam int c_hold_w = $clog2(NDM_HOLD_CYCLES + 1);

    localparam logic [c_stab_w-1:0] c_stab_last = c_stab_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [c_cpu_w-1:0]  c_cpu_last  = c_cpu_w'(CPU_DELAY_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(NDM_HOLD_CYCLES - 1);

    logic                w_lock_s;
    logic                w_btn_deb;

    seq_state_t          r_state;
    seq_state_t          w_next_state;
    logic [c_stab_w-1:0] r_stab_cnt;
    logic [c_cpu_w-1:0]  r_cpu_cnt;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_fabric_rst_n;
    logic                r_cpu_rst_n;
    logic                r_lock_lost;
    logic [1:0]          r_cause;
    logic [1:0]          w_cause_next;
    logic                w_set_lost;
    logic                w_fabric_rst_n_next;
    logic                w_cpu_rst_n_next;

    rst_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (0)
    ) u_lock_sync (
        .clk     (CLK),
        .rst     (RESET),
        .i_async (PLL_LOCK),
        .o_level (w_lock_s)
    );

    rst_sync_debounce #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_sync (
        .clk     (CLK),
        .rst     (RESET),
        .i_async (EXT_RST_N),
        .o_level (w_btn_deb)
    );

    // Next state, reset cause and registered-output targets; lock loss has top priority
    always_comb begin
        w_next_state = r_state;
        w_cause_next = r_cause;
        w_set_lost   = 1'b0;

        if (r_state != WAIT_LOCK && !w_lock_s) begin
            w_next_state = WAIT_LOCK;
            w_cause_next = CAUSE_LOCK;
            w_set_lost   = r_fabric_rst_n;
        end else if (r_state != WAIT_LOCK && !w_btn_deb) begin
            w_next_state = WAIT_LOCK;
            w_cause_next = CAUSE_BTN;
        end else begin
            case (r_state)
                WAIT_LOCK:  if (w_lock_s && w_btn_deb) w_next_state = STABILISE;
                STABILISE:  if (r_stab_cnt == c_stab_last) w_next_state = REL_FABRIC;
                REL_FABRIC: if (r_cpu_cnt == c_cpu_last) w_next_state = RUN;
                RUN: begin
                    if (NDM_RESET) begin
                        w_next_state = DBG_HOLD;
                        w_cause_next = CAUSE_DBG;
                    end
                end
                DBG_HOLD:   if (r_hold_cnt == c_hold_last && !NDM_RESET) w_next_state = REL_FABRIC;
                default:    w_next_state = WAIT_LOCK;
            endcase
        end

        // Fabric follows the next state directly; the CPU is released one cycle
        // after RUN is reached but drops together with the fabric on any exit
        w_fabric_rst_n_next = (w_next_state == REL_FABRIC) || (w_next_state == RUN) ||
                              (w_next_state == DBG_HOLD);
        w_cpu_rst_n_next    = (r_state == RUN) && (w_next_state == RUN);
    end

    // State, registered resets, sticky flag and cause
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state        <= WAIT_LOCK;
            r_fabric_rst_n <= 1'b0;
            r_cpu_rst_n    <= 1'b0;
            r_lock_lost    <= 1'b0;
            r_cause        <= CAUSE_POR;
        end else begin
            r_state        <= w_next_state;
            r_fabric_rst_n <= w_fabric_rst_n_next;
            r_cpu_rst_n    <= w_cpu_rst_n_next;
            r_cause        <= w_cause_next;
            if (w_set_lost) begin
                r_lock_lost <= 1'b1;
            end else if (CLR_STICKY) begin
                r_lock_lost <= 1'b0;
            end
        end
    end

    // Per-state saturating counters, cleared whenever their state is not being held
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_stab_cnt <= '0;
            r_cpu_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            if (r_state == STABILISE && w_next_state == STABILISE) begin
                if (r_stab_cnt != c_stab_last) r_stab_cnt <= r_stab_cnt + 1'b1;
            end else begin
                r_stab_cnt <= '0;
            end

            if (r_state == REL_FABRIC && w_next_state == REL_FABRIC) begin
                if (r_cpu_cnt != c_cpu_last) r_cpu_cnt <= r_cpu_cnt + 1'b1;
            end else begin
                r_cpu_cnt <= '0;
            end

            if (r_state == DBG_HOLD && w_next_state == DBG_HOLD) begin
                if (r_hold_cnt != c_hold_last) r_hold_cnt <= r_hold_cnt + 1'b1;
            end else begin
                r_hold_cnt <= '0;
            end
        end
    end

    assign FABRIC_RESET_N = r_fabric_rst_n;
    assign CPU_RESET_N    = r_cpu_rst_n;
    assign SEQ_STATE      = r_state;
    assign LOCK_LOST      = r_lock_lost;
    assign RESET_CAUSE    = r_cause;

endmodule : fabclk_reset_sequencer
`default_nettype wire

// File: tb/tb_fabclk_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fabclk_reset_sequencer
//  Description : Directed self-checking bench for fabclk_reset_sequencer
//                with small timing parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fabclk_reset_sequencer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       PLL_LOCK;
    logic       EXT_RST_N;
    logic       NDM_RESET;
    logic       CLR_STICKY;
    logic       FABRIC_RESET_N;
    logic       CPU_RESET_N;
    logic [2:0] SEQ_STATE;
    logic       LOCK_LOST;
    logic [1:0] RESET_CAUSE;

    int n_checks = 0;
    int n_errors = 0;
    bit order_on = 1'b0;
    int n;

    fabclk_reset_sequencer #(
        .SYNC_STAGES        (2),
        .LOCK_STABLE_CYCLES (8),
        .DEBOUNCE_CYCLES    (4),
        .CPU_DELAY_CYCLES   (3),
        .NDM_HOLD_CYCLES    (5)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .PLL_LOCK       (PLL_LOCK),
        .EXT_RST_N      (EXT_RST_N),
        .NDM_RESET      (NDM_RESET),
        .CLR_STICKY     (CLR_STICKY),
        .FABRIC_RESET_N (FABRIC_RESET_N),
        .CPU_RESET_N    (CPU_RESET_N),
        .SEQ_STATE      (SEQ_STATE),
        .LOCK_LOST      (LOCK_LOST),
        .RESET_CAUSE    (RESET_CAUSE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wait_fab(input logic lvl, output int cnt);
        cnt = 0;
        while (FABRIC_RESET_N !== lvl && cnt < 60) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_cpu(input logic lvl, output int cnt);
        cnt = 0;
        while (CPU_RESET_N !== lvl && cnt < 60) begin
            step();
            cnt++;
        end
    endtask

    task automatic wait_state(input logic [2:0] st, output int cnt);
        cnt = 0;
        while (SEQ_STATE !== st && cnt < 60) begin
            step();
            cnt++;
        end
    endtask

    // CPU must never be out of reset while the fabric is held
    always @(negedge CLK) begin
        if (order_on) check("order", {31'b0, CPU_RESET_N & ~FABRIC_RESET_N}, 32'd0);
    end

    initial begin
        RESET      = 1'b1;
        PLL_LOCK   = 1'b0;
        EXT_RST_N  = 1'b1;
        NDM_RESET  = 1'b0;
        CLR_STICKY = 1'b0;
        repeat (5) step();
        order_on = 1'b1;

        check("rst_fab",   FABRIC_RESET_N, 0);
        check("rst_cpu",   CPU_RESET_N,    0);
        check("rst_state", SEQ_STATE,      0);
        check("rst_lost",  LOCK_LOST,      0);
        check("rst_cause", RESET_CAUSE,    0);

        // Power-up: fabric after 2+8+1 cycles, CPU 4 cycles later
        RESET    = 1'b0;
        PLL_LOCK = 1'b1;
        wait_fab(1'b1, n);
        check("por_fab_lat",   n, 11);
        check("por_state_rel", SEQ_STATE, 2);
        check("por_cpu_held",  CPU_RESET_N, 0);
        wait_cpu(1'b1, n);
        check("por_cpu_lat",   n, 4);
        check("por_state_run", SEQ_STATE, 3);
        check("por_cause",     RESET_CAUSE, 0);
        check("por_lost",      LOCK_LOST, 0);

        // Lock loss in RUN, with CLR_STICKY held: setting wins
        PLL_LOCK   = 1'b0;
        CLR_STICKY = 1'b1;
        wait_fab(1'b0, n);
        CLR_STICKY = 1'b0;
        check("ll_lat",   n, 3);
        check("ll_cpu",   CPU_RESET_N, 0);
        check("ll_state", SEQ_STATE, 0);
        check("ll_lost",  LOCK_LOST, 1);
        check("ll_cause", RESET_CAUSE, 1);
        PLL_LOCK = 1'b1;
        wait_fab(1'b1, n);
        check("ll_relock_fab_lat", n, 11);
        wait_cpu(1'b1, n);
        check("ll_relock_cpu_lat", n, 4);
        check("ll_lost_sticky",    LOCK_LOST, 1);
        CLR_STICKY = 1'b1;
        step();
        CLR_STICKY = 1'b0;
        check("ll_lost_cleared", LOCK_LOST, 0);
        check("ll_cause_kept",   RESET_CAUSE, 1);

        // 3-cycle button bounce is ignored
        EXT_RST_N = 1'b0;
        repeat (3) step();
        EXT_RST_N = 1'b1;
        repeat (8) step();
        check("bounce_fab",   FABRIC_RESET_N, 1);
        check("bounce_cpu",   CPU_RESET_N, 1);
        check("bounce_state", SEQ_STATE, 3);

        // 6-cycle press: reset after 2 sync + 4 debounce + 1 cycles
        EXT_RST_N = 1'b0;
        repeat (6) step();
        EXT_RST_N = 1'b1;
        wait_fab(1'b0, n);
        check("btn_assert_lat", 6 + n, 7);
        check("btn_cpu",        CPU_RESET_N, 0);
        check("btn_state",      SEQ_STATE, 0);
        check("btn_cause",      RESET_CAUSE, 2);
        check("btn_lost",       LOCK_LOST, 0);
        wait_state(3'd1, n);
        check("btn_release_stab", n, 6);

        // Lock glitch in STABILISE restarts stabilisation, no sticky flag
        repeat (2) step();
        check("glitch_pre_state", SEQ_STATE, 1);
        PLL_LOCK = 1'b0;
        step();
        PLL_LOCK = 1'b1;
        repeat (2) step();
        check("glitch_state", SEQ_STATE, 0);
        check("glitch_lost",  LOCK_LOST, 0);
        check("glitch_cause", RESET_CAUSE, 1);
        wait_fab(1'b1, n);
        check("glitch_fab_lat", n, 9);
        wait_cpu(1'b1, n);
        check("glitch_cpu_lat", n, 4);

        // Debug reset: CPU held 5 cycles in DBG_HOLD, released 4 cycles after
        NDM_RESET = 1'b1;
        step();
        NDM_RESET = 1'b0;
        check("dbg_cpu",   CPU_RESET_N, 0);
        check("dbg_fab",   FABRIC_RESET_N, 1);
        check("dbg_state", SEQ_STATE, 4);
        check("dbg_cause", RESET_CAUSE, 3);
        repeat (4) step();
        check("dbg_hold_state", SEQ_STATE, 4);
        check("dbg_hold_cpu",   CPU_RESET_N, 0);
        step();
        check("dbg_rel_state", SEQ_STATE, 2);
        wait_cpu(1'b1, n);
        check("dbg_cpu_lat",    n, 4);
        check("dbg_fab_stayed", FABRIC_RESET_N, 1);
        check("dbg_cause_kept", RESET_CAUSE, 3);

        // RESET during REL_FABRIC returns everything to reset values
        NDM_RESET = 1'b1;
        step();
        NDM_RESET = 1'b0;
        repeat (5) step();
        check("mid_pre_state", SEQ_STATE, 2);
        RESET = 1'b1;
        step();
        check("mid_fab",   FABRIC_RESET_N, 0);
        check("mid_cpu",   CPU_RESET_N, 0);
        check("mid_state", SEQ_STATE, 0);
        check("mid_lost",  LOCK_LOST, 0);
        check("mid_cause", RESET_CAUSE, 0);

        order_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule : tb_fabclk_reset_sequencer
`default_nettype wire
